// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline controller for the 5-stage core.
//   Turns per-stage stall requests and exception/ERET requests into per-register
//   stall/flush vectors (bit 0=PC, 1=IF/ID, 2=ID/EX, 3=EX/MEM, 4=MEM/WB) and
//   sequences exception redirects: the redirect is held until the fetch unit is
//   idle, then a one-cycle registered PC redirect is issued.
// Ports:
//   clk, rst (async, active-high)
//   if_req/id_req/ex_req/mem_req : per-stage stall requests
//   if_busy                      : fetch bus transaction in flight (no redirect allowed)
//   exc_req, exc_target          : exception/ERET commit and its target address
//   stall, flush                 : combinational hold / clear vectors (flush dominates)
//   redir_valid, redir_pc        : registered one-cycle redirect strobe and target
//   busy                         : redirect sequence in progress
//   stall_cycles                 : stall-cycle counter
// Optional feature macro: PIPE_CTRL_PERF_CNT_EN enables the stall-cycle counter;
//   when undefined stall_cycles is tied to 0.
module pipe_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic              id_req,
  input  logic              ex_req,
  input  logic              mem_req,
  input  logic              if_busy,
  input  logic              exc_req,
  input  logic [ADDR_W-1:0] exc_target,
  output logic [4:0]        stall,
  output logic [4:0]        flush,
  output logic              redir_valid,
  output logic [ADDR_W-1:0] redir_pc,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] PEND  = 2'd1;
  localparam logic [1:0] REDIR = 2'd2;

  // Every stage register behind the PC is cleared during an exception; the PC
  // itself is only ever redirected, never cleared.
  localparam logic [4:0] FLUSH_EXC = 5'b11110;

  logic [1:0]        state;
  logic [1:0]        next_state;
  logic [ADDR_W-1:0] target_q;

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      RUN:     if (exc_req) next_state = if_busy ? PEND : REDIR;
      PEND:    if (!if_busy) next_state = REDIR;
      REDIR:   next_state = RUN;
      default: next_state = RUN;
    endcase
  end

  // Stall / flush decode. In RUN the highest-index request wins: everything
  // upstream of it (inclusive) holds and the register just downstream gets a bubble.
  always_comb begin
    stall = 5'b00000;
    flush = 5'b00000;
    case (state)
      RUN: begin
        if (exc_req) begin
          stall = 5'b00001;
          flush = FLUSH_EXC;
        end else if (mem_req) begin
          stall = 5'b01111;
          flush = 5'b10000;
        end else if (ex_req) begin
          stall = 5'b00111;
          flush = 5'b01000;
        end else if (id_req) begin
          stall = 5'b00011;
          flush = 5'b00100;
        end else if (if_req) begin
          stall = 5'b00001;
          flush = 5'b00010;
        end
      end
      PEND: begin
        stall = 5'b00001;
        flush = FLUSH_EXC;
      end
      REDIR: begin
        stall = 5'b00000;
        flush = FLUSH_EXC;
      end
      default: begin
        stall = 5'b00000;
        flush = 5'b00000;
      end
    endcase
  end

  assign busy = (state != RUN);

  // State, latched target and registered redirect. redir_valid is asserted for
  // exactly the cycle spent in REDIR because it is registered off next_state.
  // When entering REDIR straight from RUN the target comes from the input,
  // since target_q is being written on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      target_q    <= '0;
      redir_valid <= 1'b0;
      redir_pc    <= '0;
    end else begin
      state       <= next_state;
      redir_valid <= (next_state == REDIR);
      if (state == RUN && exc_req)
        target_q <= exc_target;
      if (next_state == REDIR)
        redir_pc <= (state == RUN) ? exc_target : target_q;
    end
  end

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_inc;

  assign cnt_inc = (state == RUN) && !exc_req && (if_req || id_req || ex_req || mem_req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else if (cnt_inc)
      cnt_q <= cnt_q + 1'b1;
  end

  assign stall_cycles = cnt_q;
`else
  assign stall_cycles = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed test-plan sequences with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model, including a mid-run asynchronous reset.
module tb_pipe_ctrl;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req, id_req, ex_req, mem_req, if_busy, exc_req;
  logic [ADDR_W-1:0] exc_target;
  logic [4:0]        stall, flush;
  logic              redir_valid, busy;
  logic [ADDR_W-1:0] redir_pc;
  logic [CNT_W-1:0]  stall_cycles;

  pipe_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .id_req(id_req), .ex_req(ex_req), .mem_req(mem_req),
    .if_busy(if_busy), .exc_req(exc_req), .exc_target(exc_target),
    .stall(stall), .flush(flush), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .busy(busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // waiting : exception accepted, redirect held back by fetch activity
  // redir   : the redirect is being presented this cycle
  bit          m_waiting, m_redir;
  logic [31:0] m_tgt, m_pc;
  int unsigned m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_waiting = 0; m_redir = 0; m_tgt = 0; m_pc = 0; m_cnt = 0;
    end else if (m_redir) begin
      m_redir = 0;
    end else if (m_waiting) begin
      if (!if_busy) begin
        m_waiting = 0; m_redir = 1; m_pc = m_tgt;
      end
    end else if (exc_req) begin
      m_tgt = exc_target;
      if (if_busy) m_waiting = 1;
      else begin m_redir = 1; m_pc = exc_target; end
    end else if (if_req || id_req || ex_req || mem_req) begin
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      logic [4:0]  e_stall, e_flush;
      logic [31:0] e_cnt;
      int k;
      e_stall = 0; e_flush = 0; k = -1;
      if (m_redir) begin
        e_flush = 5'b11110;
      end else if (m_waiting || exc_req) begin
        e_stall = 5'b00001; e_flush = 5'b11110;
      end else begin
        if (if_req)  k = 0;
        if (id_req)  k = 1;
        if (ex_req)  k = 2;
        if (mem_req) k = 3;
        if (k >= 0) begin
          e_stall = 5'((1 << (k + 1)) - 1);
          e_flush = 5'(1 << (k + 1));
        end
      end
`ifdef PIPE_CTRL_PERF_CNT_EN
      e_cnt = m_cnt;
`else
      e_cnt = 0;
`endif
      check("stall", 32'(stall), 32'(e_stall));
      check("flush", 32'(flush), 32'(e_flush));
      check("busy", 32'(busy), 32'(m_waiting | m_redir));
      check("redir_valid", 32'(redir_valid), 32'(m_redir));
      if (m_redir) check("redir_pc", redir_pc, m_pc);
      check("stall_cycles", 32'(stall_cycles), e_cnt);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input bit i, input bit d, input bit e, input bit m);
    if_req = i; id_req = d; ex_req = e; mem_req = m;
  endtask

  int unsigned exp_cnt;

  initial begin
    rst = 1'b1; exc_target = '0; if_busy = 0; exc_req = 0;
    set_req(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cmp_en = 1'b1;

    // Reset / idle
    @(negedge clk);
    check("idle_stall", 32'(stall), 32'h0);
    check("idle_flush", 32'(flush), 32'h0);
    check("idle_redir_valid", 32'(redir_valid), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_cnt", 32'(stall_cycles), 32'h0);

    // id+ex then id alone
    step(); set_req(0, 1, 1, 0);
    @(negedge clk);
    check("idex_stall", 32'(stall), 32'b00111);
    check("idex_flush", 32'(flush), 32'b01000);
    step(); set_req(0, 1, 0, 0);
    @(negedge clk);
    check("id_stall", 32'(stall), 32'b00011);
    check("id_flush", 32'(flush), 32'b00100);

    // Exception with fetch idle: redirect next cycle
    step(); set_req(0, 0, 0, 0); exc_req = 1; exc_target = 32'hBFC00380; if_busy = 0;
    @(negedge clk);
    check("exc_flush", 32'(flush), 32'b11110);
    check("exc_stall", 32'(stall), 32'b00001);
    check("exc_rv_early", 32'(redir_valid), 32'h0);
    step(); exc_req = 0;
    @(negedge clk);
    check("redir_valid", 32'(redir_valid), 32'h1);
    check("redir_pc", redir_pc, 32'hBFC00380);
    check("redir_stall", 32'(stall), 32'h0);
    check("redir_flush", 32'(flush), 32'b11110);
    step();
    @(negedge clk);
    check("post_redir_rv", 32'(redir_valid), 32'h0);
    check("post_redir_busy", 32'(busy), 32'h0);

    // Exception with fetch busy 3 cycles; second exc_req in PEND ignored
    step(); exc_req = 1; exc_target = 32'h80000180; if_busy = 1;
    @(negedge clk);
    check("pend0_flush", 32'(flush), 32'b11110);
    step(); exc_req = 1; exc_target = 32'h12345678;
    @(negedge clk);
    check("pend1_busy", 32'(busy), 32'h1);
    check("pend1_flush", 32'(flush), 32'b11110);
    step(); exc_req = 0;
    @(negedge clk);
    check("pend2_rv", 32'(redir_valid), 32'h0);
    step(); if_busy = 0;
    @(negedge clk);
    check("pend3_flush", 32'(flush), 32'b11110);
    check("pend3_stall", 32'(stall), 32'b00001);
    check("pend3_rv", 32'(redir_valid), 32'h0);
    step();
    @(negedge clk);
    check("pend_redir_valid", 32'(redir_valid), 32'h1);
    check("pend_redir_pc", redir_pc, 32'h80000180);
    step();
    @(negedge clk);
    check("pend_done_rv", 32'(redir_valid), 32'h0);

    // 5 cycles of mem_req, then exception with mem_req: exception wins
    for (int i = 0; i < 5; i++) begin
      step(); set_req(0, 0, 0, 1);
    end
    step(); exc_req = 1; exc_target = 32'h00000040;
    @(negedge clk);
    check("excmem_flush", 32'(flush), 32'b11110);
    check("excmem_stall", 32'(stall), 32'b00001);
`ifdef PIPE_CTRL_PERF_CNT_EN
    exp_cnt = 7;  // two earlier stall cycles plus five mem_req cycles
`else
    exp_cnt = 0;
`endif
    step(); exc_req = 0;
    step();
    @(negedge clk);
    check("cnt_after_exc", 32'(stall_cycles), exp_cnt);
    set_req(0, 0, 0, 0);

    // Randomized traffic, checked each cycle by the compare process
    for (int n = 0; n < 3000; n++) begin
      step();
      if (n == 1500) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      if_req  = ($urandom_range(0, 3) == 0);
      id_req  = ($urandom_range(0, 3) == 0);
      ex_req  = ($urandom_range(0, 4) == 0);
      mem_req = ($urandom_range(0, 4) == 0);
      if_busy = ($urandom_range(0, 2) == 0);
      exc_req = ($urandom_range(0, 15) == 0);
      exc_target = $urandom;
    end
    step();
    cmp_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
